// File: rtl/systolic_west_feeder_if.sv
// rtl/systolic_west_feeder_if.sv - activation vector handshake bundle for the west feeder
interface systolic_west_feeder_if #(
    parameter int ROW    = 9,
    parameter int W_DATA = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [ROW*W_DATA-1:0] s_data;
    logic                  s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/systolic_west_feeder.sv
// rtl/systolic_west_feeder.sv - FIFO-buffered diagonal skew feeder for the systolic west edge
// Optional counters enabled by defining WEST_FEEDER_STATS_EN.
module systolic_west_feeder #(
    parameter int ROW    = 9,
    parameter int W_DATA = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_sel,
    systolic_west_feeder_if.slave      s,
    output logic [ROW*(W_DATA+1)-1:0]  out_west,
    output logic                       busy,
    output logic                       done
`ifdef WEST_FEEDER_STATS_EN
    ,
    output logic [31:0]                vec_count,
    output logic [31:0]                stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int VW = ROW * W_DATA;
    localparam int LW = W_DATA + 1;
    localparam int CW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(ROW - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [VW:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          rdy_q;
    logic          empty, full, push, pop;
    logic [VW:0]   head;
    logic [ROW-1:0] lane_live;

    // Extra wrap bit on each pointer separates full from empty.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s.s_ready = rdy_q & ~full;
    assign push      = s.s_valid & s.s_ready;
    assign pop       = ~empty & ~in_sel & ((state == IDLE) || (state == STREAM));
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {s.s_last, s.s_data};
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // DRAIN spans ROW cycles so FLUSH_DONE lands one cycle after row ROW-1 shows the last vector.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, STREAM: begin
                if (pop && head[VW]) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else if (push) begin
                    state_nxt = STREAM;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) state_nxt = FLUSH_DONE;
                else                   cnt_nxt   = cnt + 1'b1;
            end
            FLUSH_DONE: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign done = (state == FLUSH_DONE);

    for (genvar r = 0; r < ROW; r++) begin : g_row
        logic [LW-1:0] pipe [r+1];
        logic [r:0]    vbits;

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                for (int k = 0; k <= r; k++) pipe[k] <= '0;
            end else begin
                pipe[0] <= pop ? {1'b1, head[r*W_DATA +: W_DATA]} : '0;
                for (int k = 1; k <= r; k++) pipe[k] <= pipe[k-1];
            end
        end

        always_comb begin
            vbits = '0;
            for (int k = 0; k <= r; k++) vbits[k] = pipe[k][W_DATA];
        end

        assign lane_live[r]            = |vbits;
        assign out_west[r*LW +: LW]    = pipe[r];
    end

    assign busy = ~empty | (|lane_live);

`ifdef WEST_FEEDER_STATS_EN
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            vec_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (vec_count != 32'hFFFF_FFFF)) vec_count <= vec_count + 1'b1;
            if (!empty && in_sel)                    stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
